// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the RV32I load-store unit.
//   lsu_state_e : access sequencer states.
//   F3_*        : funct3 size/sign codes.
//   lsu_req_t   : the request latched when an access is accepted.
//   lsu_size    : funct3 -> access size (0 byte, 1 half, 2 word).
// Related configuration macro: LSU_MISALIGN_TRAP_EN (used in lsu / lsu_fmt).
// -----------------------------------------------------------------------------
package lsu_pkg;

  // Width of the address held in the latched request. The top-level ADDR_W
  // parameter is cast into this field, so it must not exceed it.
  localparam int LSU_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [LSU_ADDR_W-1:0] addr;   // size-aligned byte address
    logic [31:0]           wdata;  // store data, already replicated
    logic [2:0]            funct3;
    logic                  we;
  } lsu_req_t;

  // Size code from funct3. The low two bits carry the size for every RV32I
  // encoding; the unused codes (011, 110, 111) land on word.
  function automatic logic [1:0] lsu_size(input logic [2:0] f3);
    logic [1:0] sz;
    case (f3[1:0])
      2'b00:   sz = 2'd0;
      2'b01:   sz = 2'd1;
      default: sz = 2'd2;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// -----------------------------------------------------------------------------
// lsu_fmt
// Purely combinational data formatting for the load-store unit.
// Ports:
//   i_funct3   : access size/sign code.
//   i_off      : raw byte offset addr[1:0].
//   i_wdata    : store data from rs2.
//   i_rdata    : word returned by data memory.
//   o_off      : offset after forcing alignment to the access size.
//   o_be       : byte enables for the access.
//   o_wdata    : store data replicated across the word.
//   o_rdata    : load data shifted down and sign/zero extended.
//   o_misalign : access is misaligned (only with LSU_MISALIGN_TRAP_EN).
// Configuration macro: LSU_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [1:0]  o_off,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [1:0]  w_size;
  logic [31:0] w_shifted;

  assign w_size = lsu_size(i_funct3);

  // Size-dependent offset, enables and store replication. Offsets are
  // rounded down to the access size; with the trap enabled a misaligned
  // access never reaches memory, so the rounding only matters without it.
  always_comb begin
    o_off   = 2'b00;
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (w_size)
      2'd0: begin
        o_off   = i_off;
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'd1: begin
        o_off   = {i_off[1], 1'b0};
        o_be    = 4'b0011 << {i_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_off   = 2'b00;
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  assign w_shifted = i_rdata >> {o_off, 3'b000};

  always_comb begin
    o_rdata = w_shifted;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_rdata = {24'h000000, w_shifted[7:0]};
      F3_HU:   o_rdata = {16'h0000, w_shifted[15:0]};
      F3_W:    o_rdata = w_shifted;
      default: o_rdata = w_shifted;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign o_misalign = ((w_size == 2'd1) && i_off[0]) ||
                      ((w_size == 2'd2) && (i_off != 2'b00));
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// MEM-stage load-store unit for the in-order RV32I pipeline. Accepts one
// load/store, runs a req/gnt/rvalid handshake to data memory, and returns
// formatted load data on lsu_rdata. Stalls the pipeline until completion.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset.
//   lsu_valid       : operation present (held stable while lsu_stall=1).
//   lsu_we          : 1 store, 0 load.
//   lsu_funct3      : RV32I size/sign code.
//   lsu_addr        : byte address.
//   lsu_wdata       : store data.
//   lsu_stall       : hold the upstream pipeline.
//   lsu_done        : one-cycle completion pulse.
//   lsu_rdata       : formatted load data, held until the next load.
//   lsu_misalign    : misaligned-access trap pulse (with the macro only).
//   dmem_req/we/addr/be/wdata : registered request to data memory.
//   dmem_gnt, dmem_rvalid, dmem_rdata : memory handshake responses.
// Configuration macro: LSU_MISALIGN_TRAP_EN (trap instead of force-align).
// -----------------------------------------------------------------------------
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_misalign,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_e r_state;
  lsu_state_e w_state_next;

  lsu_req_t    r_req;
  lsu_req_t    w_req_in;
  logic        r_dmem_req;
  logic [3:0]  r_dmem_be;
  logic [31:0] r_rdata;

  logic [2:0]  w_fmt_f3;
  logic [1:0]  w_fmt_off_in;
  logic [1:0]  w_fmt_off;
  logic [3:0]  w_fmt_be;
  logic [31:0] w_fmt_wdata;
  logic [31:0] w_fmt_rdata;
  logic        w_fmt_misalign;

  // One formatter serves both ends of an access: in IDLE it looks at the
  // incoming request (enables, store data, alignment); afterwards it looks at
  // the latched request so the returning word is extracted with the offset
  // and sign code that were accepted.
  assign w_fmt_f3     = (r_state == IDLE) ? lsu_funct3    : r_req.funct3;
  assign w_fmt_off_in = (r_state == IDLE) ? lsu_addr[1:0] : r_req.addr[1:0];

  lsu_fmt u_fmt (
    .i_funct3   (w_fmt_f3),
    .i_off      (w_fmt_off_in),
    .i_wdata    (lsu_wdata),
    .i_rdata    (dmem_rdata),
    .o_off      (w_fmt_off),
    .o_be       (w_fmt_be),
    .o_wdata    (w_fmt_wdata),
    .o_rdata    (w_fmt_rdata),
    .o_misalign (w_fmt_misalign)
  );

  always_comb begin
    w_req_in        = '0;
    w_req_in.addr   = LSU_ADDR_W'({lsu_addr[ADDR_W-1:2], w_fmt_off});
    w_req_in.wdata  = w_fmt_wdata;
    w_req_in.funct3 = lsu_funct3;
    w_req_in.we     = lsu_we;
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (lsu_valid) begin
          w_state_next = w_fmt_misalign ? DONE : REQ;
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          w_state_next = r_req.we ? DONE : RESP;
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request / response registers
  // ---------------------------------------------------------------------------
`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req      <= '0;
      r_dmem_req <= 1'b0;
      r_dmem_be  <= 4'b0000;
      r_rdata    <= 32'h0000_0000;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (lsu_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign <= w_fmt_misalign;
`endif
            // A trapped access leaves the request fields untouched.
            if (!w_fmt_misalign) begin
              r_req      <= w_req_in;
              r_dmem_be  <= w_fmt_be;
              r_dmem_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            r_dmem_req <= 1'b0;
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            r_rdata <= w_fmt_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dmem_req   = r_dmem_req;
  // Direction is only asserted alongside a live request.
  assign dmem_we    = r_dmem_req & r_req.we;
  assign dmem_addr  = ADDR_W'({r_req.addr[LSU_ADDR_W-1:2], 2'b00});
  assign dmem_be    = r_dmem_be;
  assign dmem_wdata = r_req.wdata;

  assign lsu_rdata  = r_rdata;
  assign lsu_done   = (r_state == DONE);
  assign lsu_stall  = ((r_state == IDLE) && lsu_valid) ||
                      (r_state == REQ) || (r_state == RESP);

`ifdef LSU_MISALIGN_TRAP_EN
  assign lsu_misalign = (r_state == DONE) && r_misalign;
`else
  assign lsu_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu
// Self-checking bench for lsu: directed accesses followed by randomized
// loads/stores with random memory latencies, checked against a behavioural
// model of byte enables, store replication and load extension. Ends with a
// reset taken in the middle of a read.
// Honours LSU_MISALIGN_TRAP_EN when computing expectations.
// -----------------------------------------------------------------------------
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_stall;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misalign;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  lsu #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .lsu_valid    (lsu_valid),
    .lsu_we       (lsu_we),
    .lsu_funct3   (lsu_funct3),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .lsu_stall    (lsu_stall),
    .lsu_done     (lsu_done),
    .lsu_rdata    (lsu_rdata),
    .lsu_misalign (lsu_misalign),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int eff_off(input logic [31:0] addr, input int sz);
    int a;
    a = int'(addr % 4);
    return a - (a % sz);
  endfunction

  function automatic logic [3:0] model_be(input int sz, input int off);
    int m;
    m = ((1 << sz) - 1) << off;
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int sz);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [2:0] f3,
                                             input int sz, input int off);
    logic [31:0] v;
    logic [31:0] mask;
    v = rd >> (8 * off);
    if (sz < 4) begin
      mask = 32'((64'd1 << (8 * sz)) - 64'd1);
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- one access ----------------
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int gdly, input int rdly);
    int   sz, off, cyc, req_cnt, resp_cnt, exp_done;
    logic mis, granted, saw_req, finished;
    sz  = size_of(f3);
    off = eff_off(addr, sz);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (addr % sz) != 0;
`else
    mis = 1'b0;
`endif
    exp_done = mis ? 1 : (we ? gdly + 2 : gdly + rdly + 3);
    req_cnt = 0; resp_cnt = 0; granted = 1'b0; saw_req = 1'b0; finished = 1'b0; cyc = 0;

    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    #1;
    check("stall_accept", 32'(lsu_stall), 32'd1);

    while (!finished) begin
      @(posedge clk); #1;
      cyc++;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      if (cyc > 60) begin
        check("timeout", 32'(cyc), 32'(exp_done));
        lsu_valid = 1'b0;
        finished  = 1'b1;
      end else if (lsu_done) begin
        check("done_cycle", 32'(cyc), 32'(exp_done));
        check("stall_done", 32'(lsu_stall), 32'd0);
        check("misalign", 32'(lsu_misalign), 32'(mis));
        check("req_issued", 32'(saw_req), 32'(!mis));
        if (!we && !mis) exp_rdata = model_load(rd, f3, sz, off);
        check("rdata", lsu_rdata, exp_rdata);
        lsu_valid = 1'b0;
        $display("txn %s f3=%0d addr=%08h wdata=%08h mem=%08h gnt+%0d rv+%0d done@%0d rdata=%08h mis=%0b",
                 we ? "ST" : "LD", f3, addr, wd, rd, gdly, rdly, cyc, lsu_rdata, lsu_misalign);
        @(posedge clk); #1;
        check("done_pulse", 32'(lsu_done), 32'd0);
        finished = 1'b1;
      end else begin
        check("stall_busy", 32'(lsu_stall), 32'd1);
        if (dmem_req) begin
          saw_req = 1'b1;
          check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
          check("req_be", 32'(dmem_be), 32'(model_be(sz, off)));
          check("req_we", 32'(dmem_we), 32'(we));
          if (we) check("req_wdata", dmem_wdata, model_wdata(wd, sz));
          if (req_cnt == gdly) begin
            dmem_gnt = 1'b1;
            granted  = 1'b1;
          end else begin
            dmem_rvalid = 1'($urandom_range(0, 1));  // must be ignored
          end
          req_cnt++;
        end else if (granted) begin
          if (resp_cnt == rdly) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rd;
          end else begin
            dmem_gnt = 1'($urandom_range(0, 1));     // must be ignored
          end
          resp_cnt++;
        end
      end
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"}, 32'(dmem_req), 32'd0);
    check({tag, "_we"}, 32'(dmem_we), 32'd0);
    check({tag, "_addr"}, dmem_addr, 32'd0);
    check({tag, "_be"}, 32'(dmem_be), 32'd0);
    check({tag, "_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_done"}, 32'(lsu_done), 32'd0);
    check({tag, "_stall"}, 32'(lsu_stall), 32'd0);
    check({tag, "_rdata"}, lsu_rdata, 32'd0);
    check({tag, "_mis"}, 32'(lsu_misalign), 32'd0);
  endtask

  initial begin
    logic        rw;
    logic [2:0]  f3;
    logic        got_req;
    rst = 1'b1;
    lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0; lsu_addr = 32'd0; lsu_wdata = 32'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Directed accesses
    do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    do_access(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0);
    do_access(1'b0, 3'b000, 32'h102, 32'h0, 32'h12F03456, 0, 0);
    check("lb_value", lsu_rdata, 32'hFFFFFFF0);
    do_access(1'b0, 3'b100, 32'h102, 32'h0, 32'h12F03456, 1, 0);
    check("lbu_value", lsu_rdata, 32'h000000F0);
    do_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80014567, 3, 2);
    check("lh_value", lsu_rdata, 32'hFFFF8001);
    do_access(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1);
    do_access(1'b0, 3'b101, 32'h203, 32'h0, 32'h9ABC7654, 2, 0);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom_range(0, 1));
      f3 = rw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      do_access(rw, f3, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a read; the late rvalid must be ignored.
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h200;
    got_req = 1'b0;
    for (int i = 0; i < 10 && !got_req; i++) begin
      @(posedge clk); #1;
      if (dmem_req) begin
        dmem_gnt = 1'b1;
        got_req  = 1'b1;
      end
    end
    check("rst_seq_req_seen", 32'(got_req), 32'd1);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    check("rst_seq_in_resp", 32'(lsu_stall), 32'd1);
    #2;
    rst = 1'b1; lsu_valid = 1'b0;
    #1;
    exp_rdata = 32'h0;
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555AAAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stray_rvalid_done", 32'(lsu_done), 32'd0);
      check("stray_rvalid_rdata", lsu_rdata, exp_rdata);
    end
    dmem_rvalid = 1'b0;

    // Unit still works after the abandoned access.
    do_access(1'b0, 3'b000, 32'h301, 32'h0, 32'h00008000, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load-store unit for the MEM stage of the in-order RV32I pipeline; it produces the `lsu_rdata` that writeback selects as load data. It accepts one load or store from the EX/MEM register and runs a req/gnt/rvalid handshake to data memory. It generates byte enables and replicated store data, and returns aligned, sign- or zero-extended load data. It holds the pipeline stalled until the access completes.

## Interface
Parameters:
- `ADDR_W`, 32, data-memory byte-address width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `lsu_valid` in 1: memory operation present; must stay stable while `lsu_stall`=1.
- `lsu_we` in 1: 1 = store, 0 = load.
- `lsu_funct3` in 3: RV32I size/sign code.
- `lsu_addr` in ADDR_W: byte address.
- `lsu_wdata` in 32: store data from rs2.
- `lsu_stall` out 1: hold upstream pipeline.
- `lsu_done` out 1: one-cycle completion pulse.
- `lsu_rdata` out 32: formatted load data.
- `lsu_misalign` out 1: misaligned-access trap pulse (macro-dependent).
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: request is a write.
- `dmem_addr` out ADDR_W: word-aligned address (`[1:0]`=0).
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: write data.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 32: read word.

## Operation
- FSM states and transitions:
  - IDLE: on `lsu_valid`, latch the request and go to REQ.
  - REQ: drive `dmem_req`=1 with the latched fields until `dmem_gnt`. On gnt, a store goes to DONE and a load goes to RESP.
  - RESP: on `dmem_rvalid`, capture the formatted data into `lsu_rdata` and go to DONE.
  - DONE: `lsu_done`=1, `lsu_stall`=0; unconditionally return to IDLE. No new request is accepted in DONE.
- `lsu_stall` = `(state==IDLE && lsu_valid) || state==REQ || state==RESP`.
- Byte enables from `a=addr[1:0]`:
  - Byte: `4'b0001<<a`.
  - Half: `4'b0011<<a`.
  - Word: `4'b1111`.
- Store data: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word as is.
- Load data is `dmem_rdata>>(8*a)`, then extended by funct3:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: no extension.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Other funct3 codes are treated as word.
- `lsu_rdata` holds its value until the next load completes; stores do not change it.
- `dmem_rvalid` outside RESP is ignored. `dmem_gnt` outside REQ is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `dmem_req`, `dmem_we`, `lsu_done`, `lsu_misalign`, `lsu_stall`(registered part) = 0.
  - `dmem_addr`, `dmem_be`, `dmem_wdata`, `lsu_rdata` = 0.
- Best case, store: accept at cycle 0, `dmem_req` in cycle 1, gnt in cycle 1, `lsu_done` in cycle 2.
- Best case, load: accept at cycle 0, req and gnt in cycle 1, rvalid in cycle 2, `lsu_done` and `lsu_rdata` valid in cycle 3.
- Each cycle without gnt or rvalid adds one cycle. There is no timeout.
- `dmem_*` request fields are registered and stable for the whole time `dmem_req`=1.
- Reset mid-access drops the request immediately (`dmem_req`=0). A later rvalid for the abandoned read is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half with `a[0]`=1, or a word with `a`≠0, is misaligned.
  - A misaligned access issues no dmem request; IDLE goes straight to DONE.
  - In that DONE cycle `lsu_misalign`=1 and `lsu_done`=1, and `lsu_rdata` is unchanged.
- Undefined:
  - `lsu_misalign` is tied 0.
  - Misaligned addresses are force-aligned to the access size (half clears bit 0, word clears `[1:0]`) and proceed normally.

## Structure
- Package `lsu_pkg`:
  - `lsu_state_e` {IDLE, REQ, RESP, DONE}.
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - `lsu_req_t` packed struct {addr, wdata, funct3, we}.
- One combinational sub-module, `lsu_fmt`, computes byte enables, replicated store data and load extraction/extension. The FSM stays in `lsu`.

## Test plan
- SW: addr 0x100, data 0xDEADBEEF, gnt immediate → `dmem_addr`=0x100, `be`=1111, `lsu_done` in cycle 2, stall high for cycles 0–1.
- SB: addr 0x103, data 0x000000A5 → `be`=1000, `dmem_wdata`=0xA5A5A5A5, `dmem_addr`=0x100.
- LB / LBU: addr 0x102, rdata 0x12F03456 → LB gives 0xFFFFFFF0, LBU gives 0x000000F0.
- LH: addr 0x102, rdata 0x80014567, gnt delayed 3 cycles, rvalid delayed 2 cycles → `lsu_rdata`=0xFFFF8001, `lsu_done` in cycle 8, `dmem_req` held stable throughout.
- LW: addr 0x101 → with macro: no `dmem_req`, `lsu_misalign` and `lsu_done` both pulse in cycle 1. Without macro: access to 0x100 with `be`=1111.
- Assert `rst` while in RESP, then raise rvalid after reset → state IDLE, all outputs 0, the stray rvalid produces no `lsu_done`.
